// File: rtl/multi_push_control.sv
// NUM_CH-channel button conditioner: synchroniser, debounce lockout, press/release/long pulses.
// Define PUSH_REPEAT_EN to enable auto-repeat press pulses while a button stays held after a long press.
module multi_push_control #(
  parameter int NUM_CH       = 4,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [NUM_CH-1:0] i_Push,
  output logic [NUM_CH-1:0] o_fPush,
  output logic [NUM_CH-1:0] o_fRelease,
  output logic [NUM_CH-1:0] o_fLong,
  output logic [NUM_CH-1:0] o_Level
);

  localparam int CNT_MAX_A = (DEBOUNCE_CYC > LONG_CYC) ? DEBOUNCE_CYC : LONG_CYC;
  localparam int CNT_MAX   = (CNT_MAX_A > REPEAT_CYC) ? CNT_MAX_A : REPEAT_CYC;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
`ifdef PUSH_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PULSE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_HELD   = 3'd3;
  localparam logic [2:0] S_RPULSE = 3'd4;
  localparam logic [2:0] S_RWAIT  = 3'd5;

  logic [NUM_CH-1:0] sync1_reg;
  logic [NUM_CH-1:0] sync2_reg;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= i_Push;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [2:0]    state_reg, state_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic          long_reg, long_next;
      logic          s;
      logic          push_o, rel_o, long_o, lvl_o;

      assign s = sync2_reg[gi];

      always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
          state_reg <= S_IDLE;
          cnt_reg   <= '0;
          long_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          long_reg  <= long_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        long_next  = long_reg;
        case (state_reg)
          S_IDLE:   if (s) state_next = S_PULSE;
          S_PULSE:  state_next = S_WAIT;
          S_WAIT: begin
            if (cnt_reg == DEB_LAST) state_next = s ? S_HELD : S_RPULSE;
            else                     cnt_next   = cnt_reg + CW'(1);
          end
          S_HELD: begin
            // Release wins over any long/repeat event falling on the same clock.
            if (!s) begin
              state_next = S_RPULSE;
            end else if (!long_reg) begin
              if (cnt_reg == LONG_LAST) begin
                long_next = 1'b1;
                cnt_next  = '0;
              end else begin
                cnt_next  = cnt_reg + CW'(1);
              end
            end else begin
`ifdef PUSH_REPEAT_EN
              if (cnt_reg == REP_LAST) cnt_next = '0;
              else                     cnt_next = cnt_reg + CW'(1);
`else
              cnt_next = cnt_reg;
`endif
            end
          end
          S_RPULSE: state_next = S_RWAIT;
          S_RWAIT: begin
            if (cnt_reg == DEB_LAST) state_next = S_IDLE;
            else                     cnt_next   = cnt_reg + CW'(1);
          end
          default:  state_next = S_IDLE;
        endcase
        if (state_next != state_reg) cnt_next  = '0;
        if (state_next != S_HELD)    long_next = 1'b0;
      end

      always_comb begin
        push_o = (state_reg == S_PULSE);
`ifdef PUSH_REPEAT_EN
        if (state_reg == S_HELD && long_reg && cnt_reg == REP_LAST) push_o = 1'b1;
`endif
        rel_o  = (state_reg == S_RPULSE);
        long_o = (state_reg == S_HELD) && !long_reg && (cnt_reg == LONG_LAST);
        lvl_o  = (state_reg == S_PULSE) || (state_reg == S_WAIT) || (state_reg == S_HELD);
      end

      assign o_fPush[gi]    = push_o;
      assign o_fRelease[gi] = rel_o;
      assign o_fLong[gi]    = long_o;
      assign o_Level[gi]    = lvl_o;
    end
  endgenerate

endmodule

// File: tb/tb_multi_push_control.sv
// Directed bench for multi_push_control (NUM_CH=4, DEBOUNCE_CYC=8, LONG_CYC=20, REPEAT_CYC=5).
module tb_multi_push_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] push;
  logic [3:0] o_fPush, o_fRelease, o_fLong, o_Level;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int push_cnt[4], rel_cnt[4], long_cnt[4];
  int push_first[4], push_second[4], long_first[4];

  typedef struct {
    logic [3:0] push;
    logic [3:0] e_push;
    logic [3:0] e_rel;
    logic [3:0] e_long;
    logic [3:0] e_lvl;
  } vec_t;

  vec_t tbl[16];

  multi_push_control #(
    .NUM_CH(4), .DEBOUNCE_CYC(8), .LONG_CYC(20), .REPEAT_CYC(5)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Push(push),
    .o_fPush(o_fPush), .o_fRelease(o_fRelease), .o_fLong(o_fLong), .o_Level(o_Level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end else begin
      $display("ok   %s: %0d at cycle %0d", name, act, cyc);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < 4; c++) begin
      push_cnt[c] = 0; rel_cnt[c] = 0; long_cnt[c] = 0;
      push_first[c] = -1; push_second[c] = -1; long_first[c] = -1;
    end
  endtask

  // Advance one clock, then observe outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < 4; c++) begin
      if (o_fPush[c]) begin
        push_cnt[c]++;
        if (push_first[c] < 0)       push_first[c] = cyc;
        else if (push_second[c] < 0) push_second[c] = cyc;
      end
      if (o_fRelease[c]) rel_cnt[c]++;
      if (o_fLong[c]) begin
        long_cnt[c]++;
        if (long_first[c] < 0) long_first[c] = cyc;
      end
    end
  endtask

  function automatic vec_t mk(input logic [3:0] p, input logic [3:0] ep, input logic [3:0] er,
                              input logic [3:0] el, input logic [3:0] ev);
    vec_t v;
    v.push = p; v.e_push = ep; v.e_rel = er; v.e_long = el; v.e_lvl = ev;
    return v;
  endfunction

  initial begin
    int start;
    // ch0 and ch2 rise together, held 12 clocks, then released.
    tbl[0]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[1]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h0);
    tbl[2]  = mk(4'h5, 4'h5, 4'h0, 4'h0, 4'h5);
    tbl[3]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[4]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[5]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[6]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[7]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[8]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[9]  = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[10] = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[11] = mk(4'h5, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[12] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[13] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h5);
    tbl[14] = mk(4'h0, 4'h0, 4'h5, 4'h0, 4'h0);
    tbl[15] = mk(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    clear_stats();

    // Reset with all buttons pressed, then release reset with buttons idle.
    rst_n = 1'b0;
    push  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outs", int'({o_fPush, o_fRelease, o_fLong, o_Level}), 0);
    end
    rst_n = 1'b1;
    push  = 4'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_outs", int'({o_fPush, o_fRelease, o_fLong, o_Level}), 0);
    end

    // Table-driven: simultaneous ch0/ch2 press and release.
    for (int i = 0; i < 16; i++) begin
      push = tbl[i].push;
      step();
      check($sformatf("tbl%0d_push", i), int'(o_fPush),    int'(tbl[i].e_push));
      check($sformatf("tbl%0d_rel", i),  int'(o_fRelease), int'(tbl[i].e_rel));
      check($sformatf("tbl%0d_long", i), int'(o_fLong),    int'(tbl[i].e_long));
      check($sformatf("tbl%0d_lvl", i),  int'(o_Level),    int'(tbl[i].e_lvl));
    end
    repeat (20) step();

    // ch0 steady high 12 clocks, then low.
    clear_stats();
    start = cyc;
    push  = 4'b0001;
    repeat (12) step();
    check("t2_level_held", int'(o_Level[0]), 1);
    push = 4'b0000;
    repeat (30) step();
    check("t2_push_cnt", push_cnt[0], 1);
    check("t2_push_lat", push_first[0] - start, 3);
    check("t2_rel_cnt", rel_cnt[0], 1);
    check("t2_long_cnt", long_cnt[0], 0);
    check("t2_other_ch", push_cnt[1] + push_cnt[2] + push_cnt[3], 0);

    // ch1 bounces for 6 clocks then stays high.
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      push = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      step();
    end
    push = 4'b0010;
    repeat (25) step();
    check("t3_push_cnt", push_cnt[1], 1);
    check("t3_no_rel", rel_cnt[1], 0);
    check("t3_level", int'(o_Level[1]), 1);
    push = 4'b0000;
    repeat (25) step();
    check("t3_rel_cnt", rel_cnt[1], 1);

    // ch2 held 60 clocks: long press and optional repeats.
    clear_stats();
    start = cyc;
    push  = 4'b0100;
    repeat (60) step();
    check("t4_push_lat", push_first[2] - start, 3);
    check("t4_long_cnt", long_cnt[2], 1);
    check("t4_long_at", long_first[2] - push_first[2], 28);
`ifdef PUSH_REPEAT_EN
    check("t4_push_cnt", push_cnt[2], 6);
    check("t4_first_rep", push_second[2] - push_first[2], 33);
`else
    check("t4_push_cnt", push_cnt[2], 1);
`endif
    check("t4_no_rel", rel_cnt[2], 0);
    push = 4'b0000;
    repeat (25) step();
    check("t4_rel_cnt", rel_cnt[2], 1);
    check("t4_level_off", int'(o_Level[2]), 0);

    // ch3 held, reset cut mid-press, reset released with ch3 still high.
    clear_stats();
    push = 4'b1000;
    for (int i = 0; i < 10 && push_first[3] < 0; i++) step();
    check("t5_push_seen", int'(push_first[3] >= 0), 1);
    repeat (15) step();
    check("t5_level_pre", int'(o_Level[3]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_async", int'({o_fPush, o_fRelease, o_fLong, o_Level}), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_rst_hold", int'({o_fPush, o_fRelease, o_fLong, o_Level}), 0);
    end
    check("t5_no_rel", rel_cnt[3], 0);
    clear_stats();
    start = cyc;
    rst_n = 1'b1;
    for (int i = 0; i < 10 && push_first[3] < 0; i++) step();
    check("t5_repress_lat", push_first[3] - start, 3);
    check("t5_no_rel_after", rel_cnt[3], 0);
    push = 4'b0000;
    repeat (25) step();
    check("t5_rel_cnt", rel_cnt[3], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
